// File: rtl/ascii_rotation_decoder_pkg.sv
// rtl/ascii_rotation_decoder_pkg.sv - byte constants, parser states and helpers for the rotation decoder
package ascii_rotation_pkg;

  localparam logic [7:0] L_CHAR    = 8'h4C;
  localparam logic [7:0] R_CHAR    = 8'h52;
  localparam logic [7:0] ZERO_CHAR = 8'h30;
  localparam logic [7:0] NINE_CHAR = 8'h39;
  localparam logic [7:0] LF_CHAR   = 8'h0A;
  localparam logic [7:0] CR_CHAR   = 8'h0D;

  typedef enum logic [1:0] {
    EXPECT_DIR = 2'd0,
    DIGITS     = 2'd1,
    DISCARD    = 2'd2
  } state_t;

  // True for ASCII '0'..'9'
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ZERO_CHAR) && (b <= NINE_CHAR);
  endfunction

  // True for the two direction letters
  function automatic logic is_dir(input logic [7:0] b);
    return (b == L_CHAR) || (b == R_CHAR);
  endfunction

endpackage

// File: rtl/ascii_rotation_decoder_divmod_digit_step.sv
// rtl/ascii_rotation_decoder_divmod_digit_step.sv - one decimal digit of long division by MODULUS
module divmod_digit_step
  #(
    parameter int MODULUS    = 100,
    parameter int REM_WIDTH  = 8,
    parameter int TURN_WIDTH = 16
  )
  (
    input  logic [REM_WIDTH-1:0]  rem_in,
    input  logic [TURN_WIDTH-1:0] turns_in,
    input  logic [3:0]            digit,
    output logic [REM_WIDTH-1:0]  rem_out,
    output logic [TURN_WIDTH-1:0] turns_out,
    output logic                  overflow
  );

  // rem_in*10+9 stays below 10*MODULUS, which fits in REM_WIDTH+4 bits
  localparam int T_W = REM_WIDTH + 4;
  // turns_in*10+9 always fits in TURN_WIDTH+4 bits, so the top nibble flags overflow
  localparam int W_W = TURN_WIDTH + 4;

  logic [T_W-1:0] t;
  logic [3:0]     q;
  logic [W_W-1:0] wide;

  // Shift the partial remainder one decimal place and bring the new digit in
  always_comb begin
    t = T_W'(rem_in) * T_W'(10) + T_W'(digit);
  end

  // Quotient digit by compare ladder: largest k in 0..9 with k*MODULUS <= t
  always_comb begin
    q = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (t >= T_W'(k * MODULUS)) begin
        q = 4'(k);
      end
    end
  end

  // New remainder and quotient accumulation with overflow detection
  always_comb begin
    rem_out   = REM_WIDTH'(t - T_W'(q) * T_W'(MODULUS));
    wide      = W_W'(turns_in) * W_W'(10) + W_W'(q);
    turns_out = wide[TURN_WIDTH-1:0];
    overflow  = |wide[W_W-1:TURN_WIDTH];
  end

endmodule

// File: rtl/ascii_rotation_decoder.sv
// rtl/ascii_rotation_decoder.sv - ASCII <L|R><digits>\n line parser with digit-serial divide; CR tolerance under ASCII_ROTATION_DECODER_CRLF_EN
module ascii_rotation_decoder
  import ascii_rotation_pkg::*;
  #(
    parameter int MODULUS    = 100,
    parameter int REM_WIDTH  = 8,
    parameter int TURN_WIDTH = 16,
    parameter int MAX_DIGITS = 6
  )
  (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ascii_data,
    input  logic                  ascii_valid,
    output logic                  ascii_ready,
    output logic                  rot_valid,
    input  logic                  rot_ready,
    output logic                  rot_ccw,
    output logic [REM_WIDTH-1:0]  rot_rem,
    output logic [TURN_WIDTH-1:0] rot_turns,
    output logic [REM_WIDTH-1:0]  rot_right,
    output logic                  parse_error
  );

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t                state;
  logic                  dir_q;
  logic [REM_WIDTH-1:0]  rem_q;
  logic [TURN_WIDTH-1:0] turns_q;
  logic [CNT_W-1:0]      count_q;

  logic [REM_WIDTH-1:0]  step_rem;
  logic [TURN_WIDTH-1:0] step_turns;
  logic                  step_ovf;
  logic                  accept;
  logic                  cr_skip;
  logic                  is_lf;
  logic [REM_WIDTH-1:0]  ccw_right;

  divmod_digit_step #(
    .MODULUS    (MODULUS),
    .REM_WIDTH  (REM_WIDTH),
    .TURN_WIDTH (TURN_WIDTH)
  ) u_step (
    .rem_in    (rem_q),
    .turns_in  (turns_q),
    .digit     (ascii_data[3:0]),
    .rem_out   (step_rem),
    .turns_out (step_turns),
    .overflow  (step_ovf)
  );

  // Any byte stalls while an unconsumed record sits in the output register
  assign ascii_ready = !rot_valid || rot_ready;
  assign accept      = ascii_valid && ascii_ready;
  assign is_lf       = (ascii_data == LF_CHAR);

`ifdef ASCII_ROTATION_DECODER_CRLF_EN
  assign cr_skip = (ascii_data == CR_CHAR);
`else
  assign cr_skip = 1'b0;
`endif

  // MODULUS - rem; when MODULUS == 2**REM_WIDTH the truncated constant is 0 and the wrap still gives the right value
  assign ccw_right = (rem_q == '0) ? '0 : (REM_WIDTH'(MODULUS) - rem_q);

  // Parser FSM, digit accumulators and registered record/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EXPECT_DIR;
      dir_q       <= 1'b0;
      rem_q       <= '0;
      turns_q     <= '0;
      count_q     <= '0;
      rot_valid   <= 1'b0;
      rot_ccw     <= 1'b0;
      rot_rem     <= '0;
      rot_turns   <= '0;
      rot_right   <= '0;
      parse_error <= 1'b0;
    end else begin
      parse_error <= 1'b0;
      if (rot_valid && rot_ready) begin
        rot_valid <= 1'b0;
      end
      if (accept) begin
        case (state)
          EXPECT_DIR: begin
            if (is_dir(ascii_data)) begin
              dir_q   <= (ascii_data == L_CHAR);
              rem_q   <= '0;
              turns_q <= '0;
              count_q <= '0;
              state   <= DIGITS;
            end else if (is_lf || cr_skip) begin
              state <= EXPECT_DIR;
            end else begin
              parse_error <= 1'b1;
              state       <= DISCARD;
            end
          end
          DIGITS: begin
            if (is_digit(ascii_data)) begin
              if ((count_q == CNT_W'(MAX_DIGITS)) || step_ovf) begin
                parse_error <= 1'b1;
                state       <= DISCARD;
              end else begin
                rem_q   <= step_rem;
                turns_q <= step_turns;
                count_q <= count_q + 1'b1;
              end
            end else if (is_lf) begin
              if (count_q == '0) begin
                parse_error <= 1'b1;
              end else begin
                // Overrides the drain above, so drain-and-reload leaves no bubble
                rot_valid <= 1'b1;
                rot_ccw   <= dir_q;
                rot_rem   <= rem_q;
                rot_turns <= turns_q;
                rot_right <= dir_q ? ccw_right : rem_q;
              end
              state <= EXPECT_DIR;
            end else if (cr_skip) begin
              state <= DIGITS;
            end else begin
              parse_error <= 1'b1;
              state       <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_lf) begin
              state <= EXPECT_DIR;
            end
          end
          default: begin
            state <= EXPECT_DIR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_rotation_decoder.sv
// tb/tb_ascii_rotation_decoder.sv - directed vectors against a line-level reference model with per-cycle compare
module tb_ascii_rotation_decoder;

  localparam int M   = 100;
  localparam int RW  = 8;
  localparam int TW  = 16;
  localparam int MXD = 6;

  typedef struct {
    logic ccw;
    int   rem;
    int   turns;
    int   right;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ascii_data = 8'h00;
  logic          ascii_valid = 1'b0;
  logic          ascii_ready;
  logic          rot_valid;
  logic          rot_ready = 1'b1;
  logic          rot_ccw;
  logic [RW-1:0] rot_rem;
  logic [TW-1:0] rot_turns;
  logic [RW-1:0] rot_right;
  logic          parse_error;

  int errors = 0;
  int checks = 0;

  ascii_rotation_decoder #(
    .MODULUS    (M),
    .REM_WIDTH  (RW),
    .TURN_WIDTH (TW),
    .MAX_DIGITS (MXD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .rot_valid   (rot_valid),
    .rot_ready   (rot_ready),
    .rot_ccw     (rot_ccw),
    .rot_rem     (rot_rem),
    .rot_turns   (rot_turns),
    .rot_right   (rot_right),
    .parse_error (parse_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: whole-line decimal value, divided once at the end
  rec_t    exp_q[$];
  rec_t    log_q[$];
  int      pe_count = 0;
  int      mstate = 0;
  logic    mdir = 1'b0;
  longint  mval = 0;
  int      mcnt = 0;
  logic    pe_exp = 1'b0;

`ifdef ASCII_ROTATION_DECODER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  function automatic rec_t make_rec(input logic ccw, input longint v);
    rec_t r;
    r.ccw   = ccw;
    r.rem   = int'(v % M);
    r.turns = int'(v / M);
    r.right = ccw ? ((r.rem == 0) ? 0 : M - r.rem) : r.rem;
    return r;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    longint nv;
    pe_exp = 1'b0;
    if (mstate == 0) begin
      if (b == "L" || b == "R") begin
        mdir = (b == "L"); mval = 0; mcnt = 0; mstate = 1;
      end else if (b == 8'h0A || (CRLF && b == 8'h0D)) begin
      end else begin
        pe_exp = 1'b1; mstate = 2;
      end
    end else if (mstate == 1) begin
      if (b >= "0" && b <= "9") begin
        nv = mval * 10 + longint'(b - "0");
        if (mcnt == MXD || (nv / M) > ((longint'(1) << TW) - 1)) begin
          pe_exp = 1'b1; mstate = 2;
        end else begin
          mval = nv; mcnt++;
        end
      end else if (b == 8'h0A) begin
        if (mcnt == 0) pe_exp = 1'b1;
        else exp_q.push_back(make_rec(mdir, mval));
        mstate = 0;
      end else if (CRLF && b == 8'h0D) begin
      end else begin
        pe_exp = 1'b1; mstate = 2;
      end
    end else begin
      if (b == 8'h0A) mstate = 0;
    end
  endtask

  // Compare process: mid-cycle, check outputs, then account for this cycle's handshakes
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_rot_valid", rot_valid, 0);
        chk("rst_parse_error", parse_error, 0);
        chk("rst_fields", {rot_ccw, rot_rem, rot_turns, rot_right}, 0);
        exp_q.delete();
        mstate = 0; mval = 0; mcnt = 0; pe_exp = 1'b0;
      end else begin
        chk("parse_error", parse_error, pe_exp);
        if (parse_error === 1'b1) pe_count++;
        chk("rot_valid", rot_valid, exp_q.size() > 0);
        chk("ascii_ready", ascii_ready, (exp_q.size() == 0) || rot_ready);
        if (exp_q.size() > 0) begin
          chk("rot_ccw", rot_ccw, exp_q[0].ccw);
          chk("rot_rem", rot_rem, exp_q[0].rem);
          chk("rot_turns", rot_turns, exp_q[0].turns);
          chk("rot_right", rot_right, exp_q[0].right);
        end
        pe_exp = 1'b0;
        if (rot_valid === 1'b1 && rot_ready) begin
          r.ccw = rot_ccw; r.rem = int'(rot_rem); r.turns = int'(rot_turns); r.right = int'(rot_right);
          log_q.push_back(r);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (ascii_valid && ascii_ready === 1'b1) model_byte(ascii_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int wait_cnt;
    @(negedge clk);
    ascii_data  = b;
    ascii_valid = 1'b1;
    #1;
    wait_cnt = 0;
    while (ascii_ready !== 1'b1) begin
      @(negedge clk);
      #1;
      wait_cnt++;
      if (wait_cnt > 2000) begin
        chk("ascii_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ascii_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    idle(3);
  endtask

  task automatic chk_rec(input string name, input int idx, input logic ccw, input int rem, input int turns, input int right);
    if (idx >= log_q.size()) begin
      chk({name, "_missing"}, log_q.size(), idx + 1);
    end else begin
      chk({name, "_ccw"}, log_q[idx].ccw, ccw);
      chk({name, "_rem"}, log_q[idx].rem, rem);
      chk({name, "_turns"}, log_q[idx].turns, turns);
      chk({name, "_right"}, log_q[idx].right, right);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pe_base;
    repeat (3) @(negedge clk);
    chk("reset_rot_valid", rot_valid, 0);
    chk("reset_ascii_ready", ascii_ready, 1);
    rst_n = 1'b1;
    idle(2);

    base = log_q.size(); pe_base = pe_count;
    send_str("R48\n");
    chk("t1_count", log_q.size() - base, 1);
    chk_rec("t1_r0", base, 0, 48, 0, 48);
    chk("t1_pe", pe_count - pe_base, 0);

    base = log_q.size();
    send_str("L68\nL1000\nR0\n");
    chk("t2_count", log_q.size() - base, 3);
    chk_rec("t2_r0", base, 1, 68, 0, 32);
    chk_rec("t2_r1", base + 1, 1, 0, 10, 0);
    chk_rec("t2_r2", base + 2, 0, 0, 0, 0);

    base = log_q.size(); pe_base = pe_count;
    send_str("X5\nR7\nL\n");
    chk("t3_count", log_q.size() - base, 1);
    chk_rec("t3_r0", base, 0, 7, 0, 7);
    chk("t3_pe", pe_count - pe_base, 2);

    base = log_q.size(); pe_base = pe_count;
    send_str("R1234567\nR999999\n");
    chk("t4_count", log_q.size() - base, 1);
    chk_rec("t4_r0", base, 0, 99, 9999, 99);
    chk("t4_pe", pe_count - pe_base, 1);

    base = log_q.size();
    rot_ready = 1'b0;
    fork
      send_str("R1\nR2\n");
      begin
        repeat (8) @(negedge clk);
        chk("t5_hold_valid", rot_valid, 1);
        chk("t5_hold_rem", rot_rem, 1);
        chk("t5_stall_ready", ascii_ready, 0);
        rot_ready = 1'b1;
      end
    join
    idle(3);
    chk("t5_count", log_q.size() - base, 2);
    chk_rec("t5_r0", base, 0, 1, 0, 1);
    chk_rec("t5_r1", base + 1, 0, 2, 0, 2);

    base = log_q.size();
    rot_ready = 1'b0;
    send_str("R3\n");
    @(negedge clk); rst_n = 1'b0;
    idle(2);
    chk("t6_rst_valid", rot_valid, 0);
    chk("t6_rst_rem", rot_rem, 0);
    rst_n = 1'b1; rot_ready = 1'b1;
    send_str("L12");
    @(negedge clk); rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send_str("R5\n");
    chk("t6_count", log_q.size() - base, 1);
    chk_rec("t6_r0", base, 0, 5, 0, 5);

    base = log_q.size(); pe_base = pe_count;
    send_str("R5\r\n");
    if (CRLF) begin
      chk("t7_count", log_q.size() - base, 1);
      chk_rec("t7_r0", base, 0, 5, 0, 5);
      chk("t7_pe", pe_count - pe_base, 0);
    end else begin
      chk("t7_count", log_q.size() - base, 0);
      chk("t7_pe", pe_count - pe_base, 1);
    end

    base = log_q.size();
    fork
      send_str("L5\nR123\nL250\nR0\nL100\n");
      begin
        repeat (40) begin
          @(negedge clk);
          rot_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rot_ready = 1'b1;
      end
    join
    idle(5);
    chk("t8_count", log_q.size() - base, 5);
    chk_rec("t8_r0", base, 1, 5, 0, 95);
    chk_rec("t8_r2", base + 2, 1, 50, 2, 50);
    chk_rec("t8_r4", base + 4, 1, 0, 1, 0);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
